// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared constants and types for the multi-channel clock divider.
//   IDLE/RUN  - channel state encoding
//   DIV_MIN   - smallest ratio that produces a clock; anything below is "off"
package clkdiv_pkg;
  localparam logic IDLE    = 1'b0;
  localparam logic RUN     = 1'b1;
  localparam int   DIV_MIN = 2;

  typedef enum logic {S_IDLE = IDLE, S_RUN = RUN} chan_state_t;
endpackage

// File: rtl/clkdiv_chan.sv
// clkdiv_chan: one divider channel (counter, IDLE/RUN state, pending ratio).
//   in, rst_n : clock, async active-low reset
//   en        : run enable; a stop takes effect at the period boundary
//   load, div : capture div as the pending ratio (last load wins)
//   phase     : start count captured with div (only with CLKDIV_MULTI_PHASE_EN)
//   out       : divided clock, high while count < ratio/2
//   busy      : a captured ratio is waiting to be applied
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int W    = 8,
  parameter int DIV0 = 2
) (
  input  logic         in,
  input  logic         rst_n,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] div,
`ifdef CLKDIV_MULTI_PHASE_EN
  input  logic [W-1:0] phase,
`endif
  output logic         out,
  output logic         busy
);
  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] MIN = W'(DIV_MIN);

  chan_state_t  st, st_n;
  logic [W-1:0] r, r_n, cnt, cnt_n, p, p_n;
  logic         pv, pv_n, out_n, apply;
  // ph_cur: start count when leaving IDLE; ph_app: start count on an apply
  logic [W-1:0] ph_cur, ph_app;

`ifdef CLKDIV_MULTI_PHASE_EN
  logic [W-1:0] pp, pp_n, ph, ph_n;
  assign ph_cur = ph;
  // an out-of-range phase would never reach the wrap point, so fold it to 0
  assign ph_app = (pp >= p) ? '0 : pp;

  always_comb begin
    pp_n = pp;
    ph_n = ph;
    if (apply) ph_n = ph_app;
    if (load)  pp_n = phase;
  end

  always_ff @(posedge in or negedge rst_n) begin
    if (!rst_n) begin
      pp <= '0;
      ph <= '0;
    end else begin
      pp <= pp_n;
      ph <= ph_n;
    end
  end
`else
  assign ph_cur = '0;
  assign ph_app = '0;
`endif

  always_comb begin
    st_n  = st;
    r_n   = r;
    cnt_n = cnt;
    p_n   = p;
    pv_n  = pv;
    out_n = 1'b0;
    apply = 1'b0;
    case (st)
      S_IDLE: begin
        // a pending ratio is taken first; the start comes one edge later
        if (pv) begin
          apply = 1'b1;
          r_n   = p;
        end else if (en && r >= MIN) begin
          st_n  = S_RUN;
          cnt_n = ph_cur;
          out_n = ph_cur < (r >> 1);
        end
      end
      S_RUN: begin
        if (cnt == r - ONE) begin
          // period boundary: only place ratio changes and stops happen
          cnt_n = '0;
          if (pv) begin
            apply = 1'b1;
            r_n   = p;
            cnt_n = ph_app;
          end
          if (!en || r_n < MIN) begin
            st_n  = S_IDLE;
            cnt_n = '0;
          end else begin
            out_n = cnt_n < (r_n >> 1);
          end
        end else begin
          cnt_n = cnt + ONE;
          out_n = cnt_n < (r >> 1);
        end
      end
      default: st_n = S_IDLE;
    endcase
    // a load on an apply edge is kept for the next boundary
    if (apply) pv_n = 1'b0;
    if (load) begin
      p_n  = div;
      pv_n = 1'b1;
    end
  end

  always_ff @(posedge in or negedge rst_n) begin
    if (!rst_n) begin
      st  <= S_IDLE;
      r   <= W'(DIV0);
      cnt <= '0;
      p   <= '0;
      pv  <= 1'b0;
      out <= 1'b0;
    end else begin
      st  <= st_n;
      r   <= r_n;
      cnt <= cnt_n;
      p   <= p_n;
      pv  <= pv_n;
      out <= out_n;
    end
  end

  assign busy = pv;
endmodule

// File: rtl/clkdiv_multi.sv
// clkdiv_multi: N posedge-aligned programmable clock dividers with a shared
// load strobe so all channels retune coherently.
//   in, rst_n : clock, async active-low reset
//   en[N]     : per-channel run enable
//   div[N*W]  : per-channel new ratio, channel k at div[k*W +: W]
//   load      : captures div (and phase) for every channel
//   phase     : per-channel start count (only with CLKDIV_MULTI_PHASE_EN)
//   out[N]    : divided clocks
//   busy[N]   : channel has a captured ratio not yet applied
module clkdiv_multi #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int DIV0 = 2
) (
  input  logic           in,
  input  logic           rst_n,
  input  logic [N-1:0]   en,
  input  logic [N*W-1:0] div,
  input  logic           load,
`ifdef CLKDIV_MULTI_PHASE_EN
  input  logic [N*W-1:0] phase,
`endif
  output logic [N-1:0]   out,
  output logic [N-1:0]   busy
);
  for (genvar k = 0; k < N; k++) begin : g_ch
    clkdiv_chan #(.W(W), .DIV0(DIV0)) u_ch (
      .in    (in),
      .rst_n (rst_n),
      .en    (en[k]),
      .load  (load),
      .div   (div[k*W +: W]),
`ifdef CLKDIV_MULTI_PHASE_EN
      .phase (phase[k*W +: W]),
`endif
      .out   (out[k]),
      .busy  (busy[k])
    );
  end
endmodule

// File: tb/tb_clkdiv_multi.sv
module tb_clkdiv_multi;
  localparam int N = 4;
  localparam int W = 8;
  localparam int DIV0 = 2;

  logic           in = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   en = '0;
  logic [N*W-1:0] div = '0;
  logic           load = 1'b0;
  logic [N-1:0]   out, busy;

  clkdiv_multi #(.N(N), .W(W), .DIV0(DIV0)) dut (
    .in(in), .rst_n(rst_n), .en(en), .div(div), .load(load),
    .out(out), .busy(busy)
  );

  always #5 in = ~in;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model: each running channel is anchored to the cycle its current period
  // began; its position is elapsed cycles modulo the ratio.
  int mR[N], mP[N], mt0[N];
  bit mpv[N], mrun[N];
  int cyc;
  bit app;

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      mR[k] = DIV0; mP[k] = 0; mt0[k] = 0; mpv[k] = 1'b0; mrun[k] = 1'b0;
    end
    cyc = 0;
  endfunction

  function automatic logic [N-1:0] exp_out();
    logic [N-1:0] e;
    e = '0;
    for (int k = 0; k < N; k++)
      if (mrun[k]) e[k] = ((cyc - mt0[k]) % mR[k]) < (mR[k] / 2);
    return e;
  endfunction

  function automatic logic [N-1:0] exp_busy();
    logic [N-1:0] e;
    for (int k = 0; k < N; k++) e[k] = mpv[k];
    return e;
  endfunction

  always @(posedge in) begin
    if (!rst_n) model_reset();
    else begin
      for (int k = 0; k < N; k++) begin
        app = 1'b0;
        if (!mrun[k]) begin
          if (mpv[k]) begin mR[k] = mP[k]; app = 1'b1; end
          else if (en[k] && mR[k] >= 2) begin mrun[k] = 1'b1; mt0[k] = cyc + 1; end
        end else if ((cyc - mt0[k]) % mR[k] == mR[k] - 1) begin
          if (mpv[k]) begin mR[k] = mP[k]; app = 1'b1; end
          if (!en[k] || mR[k] < 2) mrun[k] = 1'b0;
          else mt0[k] = cyc + 1;
        end
        if (app) mpv[k] = 1'b0;
        if (load) begin mP[k] = int'(div[k*W +: W]); mpv[k] = 1'b1; end
      end
      cyc++;
    end
  end

  always @(negedge in) begin
    if (chk_on) begin
      chk("model_out", 32'(out), 32'(exp_out()));
      chk("model_busy", 32'(busy), 32'(exp_busy()));
    end
  end

  task automatic tick();
    @(negedge in);
  endtask

  task automatic setdiv(input int d0, input int drest);
    div[0 +: W] = W'(d0);
    for (int k = 1; k < N; k++) div[k*W +: W] = W'(drest);
  endtask

  task automatic wait_busy0_clear();
    int n;
    n = 0;
    while (busy[0] && n < 40) begin tick(); n++; end
    chk("busy0_timeout", 32'(busy[0]), 0);
  endtask

  task automatic sample(input int n, output logic [31:0] v);
    v = '0;
    for (int i = 0; i < n; i++) begin
      v = {v[30:0], out[0]};
      tick();
    end
  endtask

  logic [31:0] v, vb;
  int nb;

  initial begin
    model_reset();
    chk_on = 1'b1;
    tick(); tick();
    chk("reset_out", 32'(out), 0);
    chk("reset_busy", 32'(busy), 0);

    // DIV0=2 on all channels, in phase
    rst_n = 1'b1; en = 4'hF;
    tick(); chk("en_start", 32'(out), 'hF);
    tick(); chk("div2_low", 32'(out), 0);
    tick(); chk("div2_high", 32'(out), 'hF);

    // async reset while out is high, then restart on first edge
    #2; rst_n = 1'b0; model_reset();
    #1; chk("async_rst_out", 32'(out), 0);
    tick(); rst_n = 1'b1;
    tick(); chk("rst_release", 32'(out), 'hF);

    // ch0 to ratio 5
    load = 1'b1; setdiv(5, 2);
    tick(); load = 1'b0; chk("load_busy", 32'(busy), 'hF);
    wait_busy0_clear();
    sample(5, v); chk("r5_period", v, 'b11000);
    chk("r5_wrap", 32'(out[0]), 1);
    en[0] = 1'b0; tick();
    sample(8, v); chk("r5_stop", v, 'b10000000);

    // ratio 6, reload to 3 at count 2
    load = 1'b1; setdiv(6, 2);
    tick(); load = 1'b0; chk("idle_busy", 32'(busy[0]), 1);
    wait_busy0_clear();
    en[0] = 1'b1;
    tick(); chk("r6_start", 32'(out[0]), 1);
    tick(); tick();
    load = 1'b1; setdiv(3, 2);
    tick(); load = 1'b0;
    nb = 0;
    while (busy[0] && nb < 20) begin nb++; tick(); end
    chk("r6_busy_len", nb, 3);
    sample(6, v); chk("r3_period", v, 'b100100);

    // ratio 0 stops the channel, ratio 4 restarts it
    load = 1'b1; setdiv(0, 2);
    tick(); load = 1'b0;
    wait_busy0_clear();
    sample(4, v); chk("div0_stop", v, 0);
    load = 1'b1; setdiv(4, 2);
    tick(); load = 1'b0;
    chk("div4_busy1", 32'(busy[0]), 1); chk("div4_out1", 32'(out[0]), 0);
    tick(); chk("div4_busy2", 32'(busy[0]), 0); chk("div4_out2", 32'(out[0]), 0);
    tick(); chk("div4_restart", 32'(out[0]), 1);

    // two loads before the boundary: last wins
    load = 1'b1; setdiv(7, 2);
    tick(); setdiv(9, 2);
    tick(); load = 1'b0;
    wait_busy0_clear();
    sample(9, v); chk("last_wins", v, 'b111100000);

    // load on the boundary: old pending applied, new one a period later
    load = 1'b1; setdiv(3, 2);
    tick(); load = 1'b0;
    repeat (7) tick();
    load = 1'b1; setdiv(5, 2);
    tick(); load = 1'b0;
    v = '0; vb = '0;
    for (int i = 0; i < 8; i++) begin
      v = {v[30:0], out[0]}; vb = {vb[30:0], busy[0]};
      tick();
    end
    chk("bnd_out", v, 'b10011000);
    chk("bnd_busy", vb, 'b11100000);

    // randomized traffic against the model
    en = 4'hF;
    repeat (3000) begin
      tick();
      load = ($urandom_range(0, 5) == 0);
      for (int k = 0; k < N; k++)
        div[k*W +: W] = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 40))
                                                     : W'($urandom_range(0, 9));
      if ($urandom_range(0, 11) == 0) begin
        int j;
        j = $urandom_range(0, N - 1);
        en[j] = ~en[j];
      end
      if ($urandom_range(0, 599) == 0) begin
        #2; rst_n = 1'b0; model_reset();
        #1; chk("rand_async_rst", 32'(out), 0);
        tick(); rst_n = 1'b1;
      end
    end
    tick();
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
